io_command_engine: RTL and testbench
====================================

# io_command_engine

Parametrised successor to the single-bank I/O path behind the UART command decoder. Accepts decoded commands over a valid/ready handshake into a command FIFO and executes them against `BANKS` independent output banks of `BANK_WIDTH` bits:
- write, set, clear, toggle and timed pulse;
- read of synchronised inputs or output state, returned over a response handshake to the status sender.

It sits between the command decoder and the sender/pad logic inside the control top level.

## Interface
- `BANKS`, 4, number of I/O banks (≥2)
- `BANK_WIDTH`, 8, bits per bank (≤ `WORD_SIZE`)
- `FIFO_DEPTH`, 4, command FIFO entries (power of two, ≥2)
- `WORD_SIZE`, 32, response word width
- `OUT_RESET`, 0, reset value of `output_io` (`BANKS*BANK_WIDTH` bits)
- Derived: `BS = $clog2(BANKS)`, `LW = $clog2(FIFO_DEPTH+1)`

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  FIFO not full
- `cmd_op`  in  3  opcode
- `cmd_bank`  in  BS  target bank
- `cmd_data`  in  BANK_WIDTH  mask/value
- `cmd_arg`  in  16  pulse length in cycles
- `input_io`  in  BANKS*BANK_WIDTH  asynchronous pad inputs
- `output_io`  out  BANKS*BANK_WIDTH  registered outputs, bank b at `[b*BANK_WIDTH +: BANK_WIDTH]`
- `valid_io`  out  1  one-cycle strobe after any `output_io` update
- `resp_valid`  out  1  response pending
- `resp_ready`  in  1  sender accepts response
- `resp_data`  out  WORD_SIZE  zero-extended bank value
- `busy`  out  1  FSM not IDLE or FIFO not empty
- `fifo_level`  out  LW  entries queued
- `bank_err`  out  1  sticky: command addressed bank ≥ `BANKS`

## Operation
- **Opcodes:**
  - 0 NOP.
  - 1 WRITE: `bank = data`.
  - 2 SET: `bank |= data`.
  - 3 CLEAR: `bank &= ~data`.
  - 4 TOGGLE: `bank ^= data`.
  - 5 READ_IN: respond with synchronised input bank.
  - 6 PULSE: `bank ^= data` for `max(arg,1)` cycles, then `^= data` again.
  - 7 READ_OUT: respond with output bank.
- **Inputs:** two-flop synchroniser per bit; READ_IN samples the second stage.
- **FIFO:** push on `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`. A push while full is refused even if a pop occurs the same cycle.
  - Pop only in IDLE.
- **FSM:**
  - IDLE: if FIFO non-empty, pop into command register → EXEC.
  - EXEC: apply opcode.
    - Write-type ops → IDLE.
    - READ ops → RESP, loading `resp_data`.
    - PULSE → PULSE, loading counter = `max(arg,1)−1`.
    - NOP → IDLE.
  - PULSE: decrement each cycle. When the counter is 0, XOR the mask again → IDLE.
  - RESP: `resp_valid` high. On `resp_ready` → IDLE. `resp_data` is stable while `resp_valid` is high.
- **Bad bank** (`cmd_bank ≥ BANKS`): in EXEC, set `bank_err`, no output change, no response → IDLE. `bank_err` is cleared only by reset.
- During PULSE, further commands stay queued. Other banks are untouched.
- Reset values:
  - `output_io=OUT_RESET`
  - `valid_io=0`, `resp_valid=0`, `resp_data=0`
  - `bank_err=0`
  - FIFO empty (`cmd_ready=1`, `fifo_level=0`, `busy=0`)
  - FSM IDLE
- Reset mid-pulse restores `OUT_RESET` immediately and does not perform the restore XOR.

## Timing
- Command accepted at edge E0 → popped at E1 (EXEC) → `output_io` updated at E2.
- `valid_io` is high for exactly the cycle after E2.
- READ: `resp_valid` rises after E2; the earliest handshake completes at E3.
- Throughput: one write-type command per 2 cycles while the FIFO is non-empty.
- PULSE with arg N: mask applied at E2, restored at E2+N. `valid_io` strobes after both edges.
- `fifo_level` updates the cycle after push/pop. Simultaneous push and pop leaves it unchanged.
- Input-to-READ_IN latency: 2 synchroniser cycles plus command latency.

## Configuration
- `IO_EDGE_CAPTURE_EN` defined:
  - A per-bit sticky rising-edge register on synchronised inputs.
  - READ_IN returns the captured bits of the bank and clears them in EXEC.
  - An edge arriving in that same cycle stays set.
- Undefined: READ_IN returns the synchronised level; no capture logic.

## Test plan
- Reset, then WRITE bank 1 `0xA5` → `output_io[15:8]=0xA5` two cycles after accept, `valid_io` one cycle, other banks `0x00`.
- SET bank 0 `0x0F`, CLEAR `0x03`, TOGGLE `0xFF` back-to-back → bank 0 ends `0xF3`, three `valid_io` strobes spaced 2 cycles.
- PULSE bank 2 mask `0x01` arg 5 → bit 16 high for exactly 5 cycles; PULSE arg 0 → high 1 cycle.
- Hold `resp_ready=0`, issue READ_OUT bank 1 then 5 writes → `resp_data=0xA5` held stable, FIFO fills to 4, `cmd_ready=0`; release → queue drains in order.
- `cmd_bank=5` with `BANKS=4` (`BS`=3 override test) → `bank_err=1`, no output change, no response.
- Edge capture: with `IO_EDGE_CAPTURE_EN`, pulse `input_io[3]` one cycle then READ_IN bank 0 → `0x08`, second READ → `0x00`. Without it, both reads return `0x00`.

Source files
------------

// File: rtl/io_command_engine.sv
// io_command_engine: queued write/set/clear/toggle/pulse/read executor over BANKS output banks.
// Latency: a command accepted at edge E0 is popped at E1 and updates output_io at E2; reads respond after E2.
// Backpressure: cmd_ready drops while the command FIFO is full; an unaccepted response stalls the queue.
// Optional feature macro: IO_EDGE_CAPTURE_EN (sticky rising-edge capture returned by READ_IN).
module io_command_engine #(
  parameter int BANKS      = 4,
  parameter int BANK_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WORD_SIZE  = 32,
  parameter logic [BANKS*BANK_WIDTH-1:0] OUT_RESET = '0,
  parameter int BS         = $clog2(BANKS),
  parameter int LW         = $clog2(FIFO_DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [BS-1:0]               cmd_bank,
  input  logic [BANK_WIDTH-1:0]       cmd_data,
  input  logic [15:0]                 cmd_arg,
  input  logic [BANKS*BANK_WIDTH-1:0] input_io,
  output logic [BANKS*BANK_WIDTH-1:0] output_io,
  output logic                        valid_io,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [WORD_SIZE-1:0]        resp_data,
  output logic                        busy,
  output logic [LW-1:0]               fifo_level,
  output logic                        bank_err
);

  localparam int NW = BANKS * BANK_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_WRITE    = 3'd1,
    OP_SET      = 3'd2,
    OP_CLEAR    = 3'd3,
    OP_TOGGLE   = 3'd4,
    OP_READ_IN  = 3'd5,
    OP_PULSE    = 3'd6,
    OP_READ_OUT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_PULSE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]            op;
    logic [BS-1:0]         bank;
    logic [BANK_WIDTH-1:0] data;
    logic [15:0]           arg;
  } cmd_t;

  state_e                state;
  cmd_t                  cur;
  logic [NW-1:0]         out_q;
  logic [15:0]           pulse_cnt;

  // ---------------------------------------------------------------- command FIFO
  cmd_t                  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  fifo_full;
  logic                  fifo_vld;
  logic                  push;
  logic                  pop;
  cmd_t                  push_dat;

  assign fifo_full = (level_q == LW'(FIFO_DEPTH));
  assign fifo_vld  = (level_q != '0);
  // full blocks a push even when a pop happens the same cycle
  assign push      = cmd_valid && !fifo_full;
  assign pop       = (state == S_IDLE) && fifo_vld;
  assign push_dat  = {cmd_op, cmd_bank, cmd_data, cmd_arg};

  // FIFO pointers and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (!push && pop) level_q <= level_q - LW'(1);
    end
  end

  // FIFO storage; contents are only read when the count says they are valid
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_dat;
  end

  // ---------------------------------------------------------------- input synchroniser
  logic [NW-1:0] sync1;
  logic [NW-1:0] sync2;
  logic [NW-1:0] in_src;

  // two-flop synchroniser on every pad input bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= input_io;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------- bank selection
  logic [31:0]           bank_idx;
  logic                  bank_ok;
  logic [BANK_WIDTH-1:0] bank_out;
  logic [BANK_WIDTH-1:0] bank_in;
  logic [BANK_WIDTH-1:0] bank_next;
  logic [BANK_WIDTH-1:0] wr_val;
  logic [NW-1:0]         out_d;

  assign bank_idx = 32'(cur.bank);
  assign bank_ok  = (bank_idx < 32'(BANKS));

  // pick the addressed bank out of the output and input vectors
  always_comb begin
    bank_out = '0;
    bank_in  = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_idx == 32'(b)) begin
        bank_out = out_q[b*BANK_WIDTH +: BANK_WIDTH];
        bank_in  = in_src[b*BANK_WIDTH +: BANK_WIDTH];
      end
    end
  end

  // new bank value for the current opcode; PULSE state undoes the mask
  always_comb begin
    bank_next = bank_out;
    case (cur.op)
      OP_WRITE:            bank_next = cur.data;
      OP_SET:              bank_next = bank_out | cur.data;
      OP_CLEAR:            bank_next = bank_out & ~cur.data;
      OP_TOGGLE, OP_PULSE: bank_next = bank_out ^ cur.data;
      default:             bank_next = bank_out;
    endcase
    wr_val = (state == S_PULSE) ? (bank_out ^ cur.data) : bank_next;
  end

  // full output vector with only the addressed bank replaced
  always_comb begin
    out_d = out_q;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_idx == 32'(b)) out_d[b*BANK_WIDTH +: BANK_WIDTH] = wr_val;
    end
  end

  // ---------------------------------------------------------------- optional edge capture
`ifdef IO_EDGE_CAPTURE_EN
  logic [NW-1:0] sync3;
  logic [NW-1:0] cap_q;
  logic [NW-1:0] cap_clr;

  // READ_IN of a valid bank clears that bank's captured bits in EXEC
  always_comb begin
    cap_clr = '0;
    if (state == S_EXEC && cur.op == OP_READ_IN && bank_ok) begin
      for (int b = 0; b < BANKS; b++) begin
        if (bank_idx == 32'(b)) cap_clr[b*BANK_WIDTH +: BANK_WIDTH] = '1;
      end
    end
  end

  // sticky rising-edge flags; a new edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync3 <= '0;
      cap_q <= '0;
    end else begin
      sync3 <= sync2;
      cap_q <= (cap_q & ~cap_clr) | (sync2 & ~sync3);
    end
  end

  assign in_src = cap_q;
`else
  assign in_src = sync2;
`endif

  // ---------------------------------------------------------------- control FSM
  // pop, execute, time pulses and hold responses until the sender takes them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cur        <= '0;
      out_q      <= OUT_RESET;
      valid_io   <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      bank_err   <= 1'b0;
      pulse_cnt  <= '0;
    end else begin
      valid_io <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_vld) begin
            cur   <= fifo_mem[rd_ptr];
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_IDLE;
          if (!bank_ok) begin
            bank_err <= 1'b1;
          end else begin
            case (cur.op)
              OP_NOP: ;
              OP_READ_IN: begin
                resp_data  <= WORD_SIZE'(bank_in);
                resp_valid <= 1'b1;
                state      <= S_RESP;
              end
              OP_READ_OUT: begin
                resp_data  <= WORD_SIZE'(bank_out);
                resp_valid <= 1'b1;
                state      <= S_RESP;
              end
              OP_PULSE: begin
                out_q     <= out_d;
                valid_io  <= 1'b1;
                pulse_cnt <= (cur.arg == 16'd0) ? 16'd0 : cur.arg - 16'd1;
                state     <= S_PULSE;
              end
              default: begin
                out_q    <= out_d;
                valid_io <= 1'b1;
              end
            endcase
          end
        end
        S_PULSE: begin
          if (pulse_cnt == 16'd0) begin
            out_q    <= out_d;
            valid_io <= 1'b1;
            state    <= S_IDLE;
          end else begin
            pulse_cnt <= pulse_cnt - 16'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign output_io  = out_q;
  assign cmd_ready  = !fifo_full;
  assign fifo_level = level_q;
  assign busy       = (state != S_IDLE) || fifo_vld;

endmodule

// File: tb/tb_io_command_engine.sv
// tb_io_command_engine: directed vectors with hand-computed results for io_command_engine.
// Latency: checks command-to-output timing, pulse widths and response hold behaviour.
// Backpressure: exercises a stalled response filling the command FIFO.
module tb_io_command_engine;

  localparam int BANKS = 4;
  localparam int BW    = 8;
  localparam int FD    = 4;
  localparam int WS    = 32;
  localparam int BS    = 3;
  localparam int LW    = 3;
  localparam int NW    = BANKS * BW;

  localparam logic [2:0] OP_WRITE    = 3'd1;
  localparam logic [2:0] OP_SET      = 3'd2;
  localparam logic [2:0] OP_CLEAR    = 3'd3;
  localparam logic [2:0] OP_TOGGLE   = 3'd4;
  localparam logic [2:0] OP_READ_IN  = 3'd5;
  localparam logic [2:0] OP_PULSE    = 3'd6;
  localparam logic [2:0] OP_READ_OUT = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [BS-1:0] cmd_bank = '0;
  logic [BW-1:0] cmd_data = '0;
  logic [15:0]   cmd_arg = '0;
  logic [NW-1:0] input_io = '0;
  logic [NW-1:0] output_io;
  logic          valid_io;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [WS-1:0] resp_data;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          bank_err;

  int total = 0;
  int bad   = 0;

  io_command_engine #(
    .BANKS(BANKS), .BANK_WIDTH(BW), .FIFO_DEPTH(FD), .WORD_SIZE(WS),
    .OUT_RESET('0), .BS(BS), .LW(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bank(cmd_bank), .cmd_data(cmd_data), .cmd_arg(cmd_arg),
    .input_io(input_io), .output_io(output_io), .valid_io(valid_io),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .fifo_level(fifo_level), .bank_err(bank_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one command and hold it until the FIFO takes it
  task automatic send(input logic [2:0] op, input logic [BS-1:0] bank,
                      input logic [BW-1:0] data, input logic [15:0] arg);
    logic acc;
    acc       = 1'b0;
    cmd_op    = op;
    cmd_bank  = bank;
    cmd_data  = data;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60 && !acc; i++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check_val("accept", 64'(acc), 64'd1);
  endtask

  // issue a read and return the response word
  task automatic do_read(input logic [2:0] op, input logic [BS-1:0] bank, output logic [WS-1:0] val);
    logic seen;
    seen = 1'b0;
    val  = '0;
    send(op, bank, 8'h00, 16'h0000);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (resp_valid) begin
        seen = 1'b1;
        val  = resp_data;
      end
    end
    check_val("resp_seen", 64'(seen), 64'd1);
    tick();
  endtask

  initial begin
    int            high;
    int            first;
    int            strobes;
    int            resps;
    logic [WS-1:0] rv;
    logic [5:0]    vpat;

    // reset
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_val("rst_out",      64'(output_io),  64'h0);
    check_val("rst_valid_io", 64'(valid_io),   64'd0);
    check_val("rst_resp_vld", 64'(resp_valid), 64'd0);
    check_val("rst_resp_dat", 64'(resp_data),  64'h0);
    check_val("rst_bank_err", 64'(bank_err),   64'd0);
    check_val("rst_cmd_rdy",  64'(cmd_ready),  64'd1);
    check_val("rst_level",    64'(fifo_level), 64'd0);
    check_val("rst_busy",     64'(busy),       64'd0);

    // WRITE bank 1 = 0xA5: visible two edges after accept, one-cycle strobe
    send(OP_WRITE, 3'd1, 8'hA5, 16'd0);
    check_val("wr_level_e0", 64'(fifo_level), 64'd1);
    tick();
    check_val("wr_out_e1",   64'(output_io),  64'h0);
    tick();
    check_val("wr_out_e2",   64'(output_io),  64'h0000_A500);
    check_val("wr_vio_e2",   64'(valid_io),   64'd1);
    tick();
    check_val("wr_vio_e3",   64'(valid_io),   64'd0);

    // SET/CLEAR/TOGGLE bank 0 back-to-back: 0x0F, 0x0C, 0xF3 with strobes every 2 cycles
    send(OP_SET,    3'd0, 8'h0F, 16'd0);
    send(OP_CLEAR,  3'd0, 8'h03, 16'd0);
    send(OP_TOGGLE, 3'd0, 8'hFF, 16'd0);
    vpat = '0;
    vpat[5] = valid_io;
    check_val("set_b0", 64'(output_io[7:0]), 64'h0F);
    for (int k = 4; k >= 0; k--) begin
      tick();
      vpat[k] = valid_io;
      if (k == 3) check_val("clr_b0", 64'(output_io[7:0]), 64'h0C);
    end
    check_val("scl_strobes", 64'(vpat), 64'b101010);
    check_val("tgl_out", 64'(output_io), 64'h0000_A5F3);

    // PULSE bank 2 bit 0, arg 5 then arg 0
    send(OP_PULSE, 3'd2, 8'h01, 16'd5);
    high = 0; first = -1; strobes = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (output_io[16]) begin
        high++;
        if (first < 0) first = k;
      end
      if (valid_io) strobes++;
    end
    check_val("p5_width",   64'(high),    64'd5);
    check_val("p5_start",   64'(first),   64'd2);
    check_val("p5_strobes", 64'(strobes), 64'd2);
    send(OP_PULSE, 3'd2, 8'h01, 16'd0);
    high = 0; strobes = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (output_io[16]) high++;
      if (valid_io) strobes++;
    end
    check_val("p0_width",   64'(high),      64'd1);
    check_val("p0_strobes", 64'(strobes),   64'd2);
    check_val("p_others",   64'(output_io), 64'h0000_A5F3);

    // stalled response: READ_OUT bank 1 then writes to bank 3 fill the FIFO
    resp_ready = 1'b0;
    send(OP_READ_OUT, 3'd1, 8'h00, 16'd0);
    send(OP_WRITE,  3'd3, 8'h11, 16'd0);
    send(OP_SET,    3'd3, 8'h22, 16'd0);
    send(OP_TOGGLE, 3'd3, 8'h01, 16'd0);
    send(OP_CLEAR,  3'd3, 8'h10, 16'd0);
    cmd_op = OP_SET; cmd_bank = 3'd3; cmd_data = 8'h80; cmd_valid = 1'b1;
    check_val("full_rdy",   64'(cmd_ready),  64'd0);
    check_val("full_level", 64'(fifo_level), 64'd4);
    check_val("full_busy",  64'(busy),       64'd1);
    for (int k = 0; k < 3; k++) begin
      check_val("hold_vld", 64'(resp_valid), 64'd1);
      check_val("hold_dat", 64'(resp_data),  64'h0000_00A5);
      tick();
    end
    check_val("hold_level", 64'(fifo_level), 64'd4);
    resp_ready = 1'b1;
    send(OP_SET, 3'd3, 8'h80, 16'd0);
    repeat (20) tick();
    check_val("drain_out",   64'(output_io),  64'hA200_A5F3);
    check_val("drain_level", 64'(fifo_level), 64'd0);
    check_val("drain_busy",  64'(busy),       64'd0);
    check_val("drain_resp",  64'(resp_valid), 64'd0);

    // bank 5 does not exist: sticky error, no output change, no response
    send(OP_WRITE, 3'd5, 8'hFF, 16'd0);
    strobes = 0; resps = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid_io) strobes++;
      if (resp_valid) resps++;
    end
    check_val("bad_err",     64'(bank_err),  64'd1);
    check_val("bad_out",     64'(output_io), 64'hA200_A5F3);
    check_val("bad_strobes", 64'(strobes),   64'd0);
    check_val("bad_resps",   64'(resps),     64'd0);

    // READ_IN of a steady input level on bank 2
    input_io = 32'h005A_0000;
    repeat (4) tick();
    do_read(OP_READ_IN, 3'd2, rv);
    check_val("rin_first", 64'(rv), 64'h5A);
    do_read(OP_READ_IN, 3'd2, rv);
`ifdef IO_EDGE_CAPTURE_EN
    check_val("rin_second", 64'(rv), 64'h00);
`else
    check_val("rin_second", 64'(rv), 64'h5A);
`endif
    input_io = '0;
    repeat (4) tick();

    // one-cycle pulse on input bit 3, then two READ_IN of bank 0
    input_io = 32'h0000_0008;
    tick();
    input_io = '0;
    repeat (4) tick();
    do_read(OP_READ_IN, 3'd0, rv);
`ifdef IO_EDGE_CAPTURE_EN
    check_val("edge_first", 64'(rv), 64'h08);
`else
    check_val("edge_first", 64'(rv), 64'h00);
`endif
    do_read(OP_READ_IN, 3'd0, rv);
    check_val("edge_second", 64'(rv), 64'h00);
    check_val("err_sticky",  64'(bank_err), 64'd1);

    // reset in the middle of a long pulse: OUT_RESET, no restore afterwards
    send(OP_PULSE, 3'd0, 8'h80, 16'd20);
    repeat (4) tick();
    check_val("mid_pulse", 64'(output_io[7:0]), 64'h73);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_out",  64'(output_io), 64'h0);
    check_val("arst_err",  64'(bank_err),  64'd0);
    check_val("arst_busy", 64'(busy),      64'd0);
    tick();
    rst = 1'b1;
    strobes = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (valid_io) strobes++;
    end
    check_val("post_rst_out",     64'(output_io), 64'h0);
    check_val("post_rst_strobes", 64'(strobes),   64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
